// File: rtl/fifo_ctl_64x16_pkg.sv
// Shared geometry for the 64x16 FIFO controller and its distributed memory.
package fifo_ctl_64x16_pkg;

    localparam int unsigned FIFO64_DEPTH = 64;
    localparam int unsigned FIFO64_AW    = 6;
    localparam int unsigned FIFO64_CW    = 7;
    localparam int unsigned FIFO64_DW    = 16;

endpackage : fifo_ctl_64x16_pkg

// File: rtl/xil_dmem_tp_64x16.sv
// 64x16 two-port distributed memory: synchronous write port, asynchronous read port.
module xil_dmem_tp_64x16
    import fifo_ctl_64x16_pkg::*;
(
    input  logic                 clk_wr,
    input  logic                 i_wr_en,
    input  logic [FIFO64_AW-1:0] i_wr_adr,
    input  logic [FIFO64_DW-1:0] i_wr_data,
    input  logic [FIFO64_AW-1:0] i_rd_adr,
    output logic [FIFO64_DW-1:0] o_rd_data
);

    logic [FIFO64_DW-1:0] mem [FIFO64_DEPTH];

    // Data array only; contents are deliberately not reset.
    always_ff @(posedge clk_wr) begin
        if (i_wr_en) begin
            mem[i_wr_adr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_adr];

endmodule : xil_dmem_tp_64x16

// File: rtl/fifo_ctl_64x16.sv
// Single-clock 64x16 FWFT FIFO controller: pointers, occupancy, status and sticky error flags.
module fifo_ctl_64x16
    import fifo_ctl_64x16_pkg::*;
#(
    parameter int unsigned AFULL_THRESH = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic [FIFO64_DW-1:0] i_wr_data,
    input  logic                 i_wr_en,
    output logic                 o_full,
    output logic                 o_afull,
    input  logic                 i_rd_en,
    output logic [FIFO64_DW-1:0] o_rd_data,
    output logic                 o_empty,
    output logic [FIFO64_CW-1:0] o_words,
    output logic                 o_ovf,
    output logic                 o_unf
);

    if ((AFULL_THRESH < 1) || (AFULL_THRESH > FIFO64_DEPTH)) begin : g_bad_thresh
        $error("fifo_ctl_64x16: AFULL_THRESH out of range 1..64");
    end

    logic [FIFO64_AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [FIFO64_AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [FIFO64_CW-1:0] cnt, cnt_nxt;
    logic                 push, pop, wr_strobe;
    logic                 ovf_nxt, unf_nxt;
    logic [FIFO64_DW-1:0] mem_rd_data;

    // Acceptance uses the registered flags; a flush overrides both requests.
    always_comb begin
        push       = i_wr_en & ~o_full;
        pop        = i_rd_en & ~o_empty;
        wr_strobe  = push & ~i_clr;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt;
        ovf_nxt    = o_ovf;
        unf_nxt    = o_unf;
        if (i_clr) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            cnt_nxt    = '0;
            ovf_nxt    = 1'b0;
            unf_nxt    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_nxt = wr_ptr + FIFO64_AW'(1);
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + FIFO64_AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_nxt = cnt + FIFO64_CW'(1);
                2'b01:   cnt_nxt = cnt - FIFO64_CW'(1);
                default: cnt_nxt = cnt;
            endcase
            ovf_nxt = o_ovf | (i_wr_en & o_full);
            unf_nxt = o_unf | (i_rd_en & o_empty);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
            o_afull <= 1'b0;
            o_ovf   <= 1'b0;
            o_unf   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            cnt     <= cnt_nxt;
            o_full  <= (cnt_nxt == FIFO64_CW'(FIFO64_DEPTH));
            o_empty <= (cnt_nxt == '0);
            o_afull <= (cnt_nxt >= FIFO64_CW'(AFULL_THRESH));
            o_ovf   <= ovf_nxt;
            o_unf   <= unf_nxt;
        end
    end

    xil_dmem_tp_64x16 u_mem (
        .clk_wr    (clk),
        .i_wr_en   (wr_strobe),
        .i_wr_adr  (wr_ptr),
        .i_wr_data (i_wr_data),
        .i_rd_adr  (rd_ptr),
        .o_rd_data (mem_rd_data)
    );

    // Stale memory is never exposed while the FIFO is empty.
    assign o_rd_data = o_empty ? '0 : mem_rd_data;
    assign o_words   = cnt;

endmodule : fifo_ctl_64x16

// File: tb/tb_fifo_ctl_64x16.sv
// Bench for fifo_ctl_64x16: vector table, directed corner sequences and a queue-based random model.
module tb_fifo_ctl_64x16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        full, afull, empty, ovf, unf;
    logic [15:0] rd_data;
    logic [6:0]  words;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    always #5 clk = ~clk;

    fifo_ctl_64x16 #(.AFULL_THRESH(48)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (clr),
        .i_wr_data (wr_data),
        .i_wr_en   (wr_en),
        .o_full    (full),
        .o_afull   (afull),
        .i_rd_en   (rd_en),
        .o_rd_data (rd_data),
        .o_empty   (empty),
        .o_words   (words),
        .o_ovf     (ovf),
        .o_unf     (unf)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic        cl;
        logic [15:0] d;
        int          exp_words;
        logic        exp_empty;
        logic [15:0] exp_data;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference behaviour: a queue plus two sticky bits, judged on pre-edge occupancy.
    task automatic model_update(input logic wr, input logic rd, input logic cl, input logic [15:0] d);
        logic was_full, was_empty;
        if (cl) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (q.size() == 64);
            was_empty = (q.size() == 0);
            if (rd && !was_empty) void'(q.pop_front());
            if (wr && !was_full) q.push_back(d);
            if (wr && was_full)  m_ovf = 1'b1;
            if (rd && was_empty) m_unf = 1'b1;
        end
    endtask

    task automatic compare_model();
        chk("m_words", 32'(words), 32'(q.size()));
        chk("m_empty", 32'(empty), 32'(q.size() == 0));
        chk("m_full",  32'(full),  32'(q.size() == 64));
        chk("m_afull", 32'(afull), 32'(q.size() >= 48));
        chk("m_data",  32'(rd_data), (q.size() == 0) ? 32'h0 : 32'(q[0]));
        chk("m_ovf",   32'(ovf), 32'(m_ovf));
        chk("m_unf",   32'(unf), 32'(m_unf));
    endtask

    task automatic step(input logic wr, input logic rd, input logic cl, input logic [15:0] d);
        wr_en   = wr;
        rd_en   = rd;
        clr     = cl;
        wr_data = d;
        @(posedge clk);
        model_update(wr, rd, cl, d);
        #1;
        compare_model();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'h1);
        chk({tag, "_words"}, 32'(words), 32'h0);
        chk({tag, "_data"},  32'(rd_data), 32'h0);
        chk({tag, "_full"},  32'(full), 32'h0);
        chk({tag, "_afull"}, 32'(afull), 32'h0);
        chk({tag, "_ovf"},   32'(ovf), 32'h0);
        chk({tag, "_unf"},   32'(unf), 32'h0);
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 1, 1'b0, 16'h1234, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 16'h0000, 1'b0, 1'b1};
        vt[3] = '{1'b1, 1'b1, 1'b0, 16'h0055, 1, 1'b0, 16'h0055, 1'b0, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b0, 16'h0077, 2, 1'b0, 16'h0055, 1'b0, 1'b1};
        vt[5] = '{1'b1, 1'b1, 1'b0, 16'h0099, 2, 1'b0, 16'h0077, 1'b0, 1'b1};
        vt[6] = '{1'b1, 1'b0, 1'b1, 16'h00AA, 0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vt[7] = '{1'b1, 1'b0, 1'b0, 16'h00BB, 1, 1'b0, 16'h00BB, 1'b0, 1'b0};

        // Reset and idle.
        #12;
        chk_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0);
        chk_reset_values("idle");

        // Vector table: single-word latency, underflow, simultaneous ops, flush priority.
        for (int i = 0; i < 8; i++) begin
            step(vt[i].wr, vt[i].rd, vt[i].cl, vt[i].d);
            chk($sformatf("vec%0d_words", i), 32'(words), 32'(vt[i].exp_words));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].exp_empty));
            chk($sformatf("vec%0d_data", i),  32'(rd_data), 32'(vt[i].exp_data));
            chk($sformatf("vec%0d_ovf", i),   32'(ovf), 32'(vt[i].exp_ovf));
            chk($sformatf("vec%0d_unf", i),   32'(unf), 32'(vt[i].exp_unf));
        end
        step(1'b0, 1'b0, 1'b1, 16'h0);

        // Fill 64 words: afull from the 48th push, full from the 64th.
        for (int i = 1; i <= 64; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'hA000 + 16'(i));
            chk("fill_afull", 32'(afull), 32'(i >= 48));
            chk("fill_full",  32'(full),  32'(i == 64));
        end
        chk("fill_words", 32'(words), 32'd64);
        for (int i = 1; i <= 64; i++) begin
            chk("drain_data", 32'(rd_data), 32'(16'hA000 + 16'(i)));
            step(1'b0, 1'b1, 1'b0, 16'h0);
        end
        chk("drain_empty", 32'(empty), 32'h1);
        chk("drain_data0", 32'(rd_data), 32'h0);

        // Full with push+pop: pop wins, push rejected, ovf sets.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, 16'hC000 + 16'(i));
        step(1'b1, 1'b1, 1'b0, 16'hDEAD);
        chk("fullboth_words", 32'(words), 32'd63);
        chk("fullboth_head",  32'(rd_data), 32'hC001);
        chk("fullboth_ovf",   32'(ovf), 32'h1);

        // Hold 20 words with ovf set, then flush together with a push.
        for (int i = 0; i < 43; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
        chk("hold20_words", 32'(words), 32'd20);
        step(1'b1, 1'b0, 1'b1, 16'hBEEF);
        chk("clr_words", 32'(words), 32'd0);
        chk("clr_empty", 32'(empty), 32'h1);
        chk("clr_ovf",   32'(ovf), 32'h0);
        step(1'b1, 1'b0, 1'b0, 16'h4242);
        chk("clr_next_words", 32'(words), 32'd1);
        chk("clr_next_data",  32'(rd_data), 32'h4242);
        step(1'b0, 1'b0, 1'b1, 16'h0);

        // Steady 30-word occupancy with simultaneous push/pop across the wrap.
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom));
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'($urandom));
            chk("steady_words", 32'(words), 32'd30);
        end

        // Randomised traffic with phases biased toward fill and drain.
        for (int blk = 0; blk < 16; blk++) begin
            int wp;
            wp = (blk % 2 == 0) ? 3 : 1;
            for (int i = 0; i < 150; i++) begin
                step(($urandom_range(0, 3) < 32'(wp)), ($urandom_range(0, 3) < 32'(4 - wp)),
                     ($urandom_range(0, 299) == 0), 16'($urandom));
            end
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom));
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 16'h5A5A;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h7777);
        chk("postrst_data", 32'(rd_data), 32'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_ctl_64x16
